// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU command path: command types, scheduler state
// encoding and the packed layout of a queued command entry.
package gpu_pkg;

  localparam logic CMD_DRAW  = 1'b0;
  localparam logic CMD_CLEAR = 1'b1;

  // One-hot to match the encoding used inside the GPU engine.
  typedef enum logic [4:0] {
    StIdle     = 5'b00001,
    StSetup    = 5'b00010,
    StStrobe   = 5'b00100,
    StWaitBusy = 5'b01000,
    StWaitDone = 5'b10000
  } state_e;

  // Coordinate fields carry two guard bits beyond the framebuffer extent.
  function automatic int unsigned coord_width(input int unsigned extent);
    return $clog2(extent) + 2;
  endfunction

  // Entry layout, LSB first: color, y, height, x, width, image_width,
  // address_y, address_x, address, type.
  localparam int unsigned OFF_COLOR = 0;
  localparam int unsigned OFF_Y     = 16;

  function automatic int unsigned off_height(input int unsigned h);
    return OFF_Y + h;
  endfunction

  function automatic int unsigned off_x(input int unsigned h);
    return OFF_Y + 2 * h;
  endfunction

  function automatic int unsigned off_width(input int unsigned w, input int unsigned h);
    return off_x(h) + w;
  endfunction

  function automatic int unsigned off_image_width(input int unsigned w, input int unsigned h);
    return off_x(h) + 2 * w;
  endfunction

  function automatic int unsigned off_address_y(input int unsigned w, input int unsigned h);
    return off_image_width(w, h) + 16;
  endfunction

  function automatic int unsigned off_address_x(input int unsigned w, input int unsigned h);
    return off_image_width(w, h) + 32;
  endfunction

  function automatic int unsigned off_address(input int unsigned w, input int unsigned h);
    return off_image_width(w, h) + 48;
  endfunction

  function automatic int unsigned off_type(input int unsigned w, input int unsigned h);
    return off_image_width(w, h) + 80;
  endfunction

  function automatic int unsigned entry_width(input int unsigned w, input int unsigned h);
    return off_type(w, h) + 1;
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous FIFO with an exposed head entry, a full flush and a
// flush-to-head that keeps only the entry currently being executed.
module gpu_cmd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_all_i,
  input  logic                     flush_head_i,
  output logic [Width-1:0]         head_o,
  output logic                     ready_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign ready_o = count_q < CW'(Depth);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  always_comb begin
    do_push = push_i && ready_o && !flush_all_i && !flush_head_i;
    do_pop  = pop_i && (count_q != '0);
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_all_i) begin
      wptr_d  = rptr_q;
      count_d = '0;
    end else if (flush_head_i && (count_q != '0)) begin
      // Head completing in the same cycle leaves nothing behind.
      if (do_pop) begin
        rptr_d  = rptr_q + 1'b1;
        wptr_d  = rptr_q + 1'b1;
        count_d = '0;
      end else begin
        wptr_d  = rptr_q + 1'b1;
        count_d = CW'(1);
      end
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gpu_cmd_queue.sv
// Queues draw/clear commands and issues them one at a time to the GPU: fields a
// cycle ahead of a clean rising strobe, held until the GPU drops busy.
module gpu_cmd_queue
  import gpu_pkg::*;
#(
  parameter int unsigned FB_WIDTH     = 400,
  parameter int unsigned FB_HEIGHT    = 240,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned BUSY_TIMEOUT = 4,
  localparam int unsigned W = coord_width(FB_WIDTH),
  localparam int unsigned H = coord_width(FB_HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_type,
  input  logic [31:0]              cmd_address,
  input  logic [15:0]              cmd_address_x,
  input  logic [15:0]              cmd_address_y,
  input  logic [15:0]              cmd_image_width,
  input  logic [W-1:0]             cmd_width,
  input  logic [W-1:0]             cmd_x,
  input  logic [H-1:0]             cmd_height,
  input  logic [H-1:0]             cmd_y,
  input  logic [15:0]              cmd_clear_color,
  input  logic                     flush,
  output logic [31:0]              ctrl_address,
  output logic [15:0]              ctrl_address_x,
  output logic [15:0]              ctrl_address_y,
  output logic [15:0]              ctrl_image_width,
  output logic [W-1:0]             ctrl_width,
  output logic [W-1:0]             ctrl_x,
  output logic [H-1:0]             ctrl_height,
  output logic [H-1:0]             ctrl_y,
  output logic [15:0]              ctrl_clear_color,
  output logic                     ctrl_draw,
  output logic                     ctrl_clear,
  input  logic                     gpu_busy,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     cmd_done,
  output logic                     cmd_error,
  output logic                     idle
);

  localparam int unsigned EW = entry_width(W, H);
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned OT = off_type(W, H);

  state_e          state_q, state_d;
  logic [EW-1:0]   push_entry, fifo_head, head_q;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            done_q, done_d, error_q, error_d;
  logic            load, pop, flush_all, flush_head, strobe_on;

  assign push_entry = {cmd_type, cmd_address, cmd_address_x, cmd_address_y, cmd_image_width,
                       cmd_width, cmd_x, cmd_height, cmd_y, cmd_clear_color};

  gpu_cmd_fifo #(
    .Width (EW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (cmd_valid && !flush),
    .wdata_i      (push_entry),
    .pop_i        (pop),
    .flush_all_i  (flush_all),
    .flush_head_i (flush_head),
    .head_o       (fifo_head),
    .ready_o      (cmd_ready),
    .count_o      (queue_count)
  );

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    load       = 1'b0;
    pop        = 1'b0;
    done_d     = 1'b0;
    flush_all  = 1'b0;
    flush_head = 1'b0;
    error_d    = flush ? 1'b0 : error_q;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          flush_all = 1'b1;
        end else if (queue_count != '0) begin
          load    = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (flush) begin
          flush_all = 1'b1;
          state_d   = StIdle;
        end else begin
          state_d = StStrobe;
        end
      end
      StStrobe: begin
        flush_head = flush;
        tmo_d      = '0;
        state_d    = StWaitBusy;
      end
      StWaitBusy: begin
        // The GPU cannot abort, so flush only trims the queue behind the head.
        flush_head = flush;
        if (gpu_busy) begin
          state_d = StWaitDone;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          error_d = 1'b1;
          pop     = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWaitDone: begin
        flush_head = flush;
        if (!gpu_busy) begin
          pop     = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      head_q  <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) head_q <= fifo_head;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign strobe_on = (state_q == StStrobe) || (state_q == StWaitBusy) ||
                     (state_q == StWaitDone);

  assign ctrl_clear_color = head_q[OFF_COLOR +: 16];
  assign ctrl_y           = head_q[OFF_Y +: H];
  assign ctrl_height      = head_q[off_height(H) +: H];
  assign ctrl_x           = head_q[off_x(H) +: W];
  assign ctrl_width       = head_q[off_width(W, H) +: W];
  assign ctrl_image_width = head_q[off_image_width(W, H) +: 16];
  assign ctrl_address_y   = head_q[off_address_y(W, H) +: 16];
  assign ctrl_address_x   = head_q[off_address_x(W, H) +: 16];
  assign ctrl_address     = head_q[off_address(W, H) +: 32];
  assign ctrl_draw        = strobe_on && (head_q[OT] == CMD_DRAW);
  assign ctrl_clear       = strobe_on && (head_q[OT] == CMD_CLEAR);

  assign cmd_done  = done_q;
  assign cmd_error = error_q;
  assign idle      = (queue_count == '0) && (state_q == StIdle) && !gpu_busy;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Directed bench for gpu_cmd_queue with a simple GPU busy model and a strobe
// monitor that logs issue order, strobe gaps and field stability.
module tb_gpu_cmd_queue;

  localparam int unsigned FB_WIDTH     = 400;
  localparam int unsigned FB_HEIGHT    = 240;
  localparam int unsigned DEPTH        = 8;
  localparam int unsigned BUSY_TIMEOUT = 4;
  localparam int unsigned W  = $clog2(FB_WIDTH) + 2;
  localparam int unsigned H  = $clog2(FB_HEIGHT) + 2;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_type;
  logic [31:0]   cmd_address;
  logic [15:0]   cmd_address_x, cmd_address_y, cmd_image_width, cmd_clear_color;
  logic [W-1:0]  cmd_width, cmd_x;
  logic [H-1:0]  cmd_height, cmd_y;
  logic          flush;
  logic [31:0]   ctrl_address;
  logic [15:0]   ctrl_address_x, ctrl_address_y, ctrl_image_width, ctrl_clear_color;
  logic [W-1:0]  ctrl_width, ctrl_x;
  logic [H-1:0]  ctrl_height, ctrl_y;
  logic          ctrl_draw, ctrl_clear;
  logic          gpu_busy;
  logic [CW-1:0] queue_count;
  logic          cmd_done, cmd_error, idle;

  always #5 clk = ~clk;

  gpu_cmd_queue #(
    .FB_WIDTH     (FB_WIDTH),
    .FB_HEIGHT    (FB_HEIGHT),
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_type         (cmd_type),
    .cmd_address      (cmd_address),
    .cmd_address_x    (cmd_address_x),
    .cmd_address_y    (cmd_address_y),
    .cmd_image_width  (cmd_image_width),
    .cmd_width        (cmd_width),
    .cmd_x            (cmd_x),
    .cmd_height       (cmd_height),
    .cmd_y            (cmd_y),
    .cmd_clear_color  (cmd_clear_color),
    .flush            (flush),
    .ctrl_address     (ctrl_address),
    .ctrl_address_x   (ctrl_address_x),
    .ctrl_address_y   (ctrl_address_y),
    .ctrl_image_width (ctrl_image_width),
    .ctrl_width       (ctrl_width),
    .ctrl_x           (ctrl_x),
    .ctrl_height      (ctrl_height),
    .ctrl_y           (ctrl_y),
    .ctrl_clear_color (ctrl_clear_color),
    .ctrl_draw        (ctrl_draw),
    .ctrl_clear       (ctrl_clear),
    .gpu_busy         (gpu_busy),
    .queue_count      (queue_count),
    .cmd_done         (cmd_done),
    .cmd_error        (cmd_error),
    .idle             (idle)
  );

  // GPU model: busy for busy_len cycles starting the cycle after a strobe rise.
  int   busy_len   = 9;
  bit   never_busy = 1'b0;
  int   busy_left;
  logic strobe_seen;
  wire  strobe = ctrl_draw | ctrl_clear;

  always @(posedge clk) begin
    if (!rst_n) begin
      gpu_busy    <= 1'b0;
      busy_left   <= 0;
      strobe_seen <= 1'b0;
    end else begin
      strobe_seen <= strobe;
      if (strobe && !strobe_seen && !never_busy) begin
        gpu_busy  <= 1'b1;
        busy_left <= busy_len - 1;
      end else if (busy_left != 0) begin
        busy_left <= busy_left - 1;
      end else begin
        gpu_busy <= 1'b0;
      end
    end
  end

  // Strobe monitor.
  wire [137:0] fields_now = {ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
                             ctrl_width, ctrl_x, ctrl_height, ctrl_y, ctrl_clear_color};
  logic [137:0] snap;
  logic         s_prev = 1'b0;
  int rise_cnt = 0, clear_rise = 0, done_cnt = 0, draw_hi = 0, both_cnt = 0, chg_cnt = 0;
  int low_run = 100, min_low = 100;
  logic         type_log  [64];
  logic [W-1:0] x_log     [64];
  logic [15:0]  color_log [64];

  always @(negedge clk) begin
    if (cmd_done) done_cnt++;
    if (ctrl_draw) draw_hi++;
    if (ctrl_draw && ctrl_clear) both_cnt++;
    if (strobe) begin
      if (!s_prev) begin
        if (low_run < min_low) min_low = low_run;
        type_log[rise_cnt % 64]  = ctrl_clear;
        x_log[rise_cnt % 64]     = ctrl_x;
        color_log[rise_cnt % 64] = ctrl_clear_color;
        snap = fields_now;
        rise_cnt++;
        if (ctrl_clear) clear_rise++;
      end else if (fields_now !== snap) begin
        chg_cnt++;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    s_prev = strobe;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_cmd(input logic typ, input int x, input int y, input int w, input int h,
                           input logic [15:0] color);
    cmd_valid       = 1'b1;
    cmd_type        = typ;
    cmd_x           = W'(x);
    cmd_y           = H'(y);
    cmd_width       = W'(w);
    cmd_height      = H'(h);
    cmd_clear_color = color;
    cmd_address     = 32'h1000_0000 + 32'(x);
    cmd_address_x   = 16'(x + 1);
    cmd_address_y   = 16'(y + 2);
    cmd_image_width = 16'd320;
  endtask

  task automatic push_one(input logic typ, input int x, input int y, input int w, input int h,
                          input logic [15:0] color);
    drive_cmd(typ, x, y, w, h, color);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = idle;
    end
    check(tag, seen, 1);
    repeat (2) @(negedge clk);
  endtask

  int base_rise, base_clear, base_done, base_draw, base_chg, done_cyc;
  logic [CW-1:0] cnt_at;
  logic idle_at;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    cmd_valid = 1'b0;
    drive_cmd(1'b0, 0, 0, 0, 0, 16'h0);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_draw", ctrl_draw, 0);
    check("rst_clear", ctrl_clear, 0);
    check("rst_count", queue_count, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", cmd_done, 0);
    check("rst_error", cmd_error, 0);
    check("rst_idle", idle, 1);
    check("rst_addr", ctrl_address, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single draw, cycle-exact
    base_rise = rise_cnt; base_done = done_cnt; base_chg = chg_cnt;
    push_one(1'b0, 10, 20, 4, 2, 16'h0);
    check("t1_c1_count", queue_count, 1);
    check("t1_c1_idle", idle, 0);
    @(negedge clk);
    check("t1_c2_width", ctrl_width, 4);
    check("t1_c2_height", ctrl_height, 2);
    check("t1_c2_x", ctrl_x, 10);
    check("t1_c2_y", ctrl_y, 20);
    check("t1_c2_addr", ctrl_address, 32'h1000_000A);
    check("t1_c2_draw", ctrl_draw, 0);
    @(negedge clk);
    check("t1_c3_draw", ctrl_draw, 1);
    check("t1_c3_clear", ctrl_clear, 0);
    done_cyc = 0; cnt_at = '1; idle_at = 1'b0;
    for (int c = 4; c <= 40; c++) begin
      @(negedge clk);
      if (cmd_done && done_cyc == 0) begin
        done_cyc = c; cnt_at = queue_count; idle_at = idle;
      end
    end
    check("t1_done_cycle", done_cyc, 14);
    check("t1_done_count", cnt_at, 0);
    check("t1_done_idle", idle_at, 1);
    check("t1_done_pulses", done_cnt - base_done, 1);
    check("t1_rises", rise_cnt - base_rise, 1);
    check("t1_field_stable", chg_cnt - base_chg, 0);

    // Eight alternating commands, ninth held off
    base_rise = rise_cnt; base_done = done_cnt;
    for (int i = 0; i < 8; i++) begin
      drive_cmd(i[0], i * 3 + 1, i, 5, 3, 16'(i));
      @(negedge clk);
    end
    check("t2_full_ready", cmd_ready, 0);
    check("t2_full_count", queue_count, 8);
    drive_cmd(1'b0, 99, 9, 5, 3, 16'h9);
    repeat (2) @(negedge clk);
    check("t2_held_count", queue_count, 8);
    cmd_valid = 1'b0;
    wait_idle(400, "t2_idle_timeout");
    check("t2_rises", rise_cnt - base_rise, 8);
    check("t2_dones", done_cnt - base_done, 8);
    check("t2_count", queue_count, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_type%0d", i), type_log[(base_rise + i) % 64], i[0]);
      check($sformatf("t2_x%0d", i), x_log[(base_rise + i) % 64], i * 3 + 1);
    end
    check("t2_min_low_ge2", min_low >= 2, 1);

    // Clear with color 0xF801
    base_rise = rise_cnt; base_clear = clear_rise; base_draw = draw_hi; base_chg = chg_cnt;
    push_one(1'b1, 0, 0, 0, 0, 16'hF801);
    wait_idle(60, "t3_idle_timeout");
    check("t3_rises", rise_cnt - base_rise, 1);
    check("t3_clear_rises", clear_rise - base_clear, 1);
    check("t3_draw_high", draw_hi - base_draw, 0);
    check("t3_color_at_rise", color_log[base_rise % 64], 16'hF801);
    check("t3_field_stable", chg_cnt - base_chg, 0);
    check("t3_color_after", ctrl_clear_color, 16'hF801);

    // Busy timeout, cycle-exact
    never_busy = 1'b1;
    push_one(1'b0, 7, 7, 1, 1, 16'h0);
    repeat (6) @(negedge clk);
    check("t4_c7_draw", ctrl_draw, 1);
    check("t4_c7_error", cmd_error, 0);
    check("t4_c7_done", cmd_done, 0);
    @(negedge clk);
    check("t4_c8_error", cmd_error, 1);
    check("t4_c8_done", cmd_done, 1);
    check("t4_c8_count", queue_count, 0);
    @(negedge clk);
    check("t4_c9_error_sticky", cmd_error, 1);
    check("t4_c9_done", cmd_done, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t4_flush_clears", cmd_error, 0);
    never_busy = 1'b0;
    repeat (2) @(negedge clk);

    // Five queued, flush during WAIT_DONE of the first
    base_rise = rise_cnt;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(1'b0, 30 + i, 1, 2, 2, 16'h0);
      @(negedge clk);
    end
    check("t5_busy", gpu_busy, 1);
    check("t5_count5", queue_count, 5);
    flush = 1'b1;
    drive_cmd(1'b1, 77, 1, 2, 2, 16'h0);
    @(negedge clk);
    flush = 1'b0;
    cmd_valid = 1'b0;
    check("t5_count1", queue_count, 1);
    check("t5_still_issued", ctrl_draw, 1);
    done_cyc = 0; cnt_at = '1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (cmd_done && done_cyc == 0) begin
        done_cyc = 1; cnt_at = queue_count;
      end
    end
    check("t5_done_seen", done_cyc, 1);
    check("t5_done_count", cnt_at, 0);
    check("t5_rises", rise_cnt - base_rise, 1);
    check("t5_idle", idle, 1);

    // Reset mid WAIT_DONE with three queued
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1'b1, 50 + i, 1, 2, 2, 16'h1234);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("t6_count3", queue_count, 3);
    repeat (2) @(negedge clk);
    check("t6_busy", gpu_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_draw", ctrl_draw, 0);
    check("t6_clear", ctrl_clear, 0);
    check("t6_count", queue_count, 0);
    check("t6_ready", cmd_ready, 1);
    check("t6_idle", idle, 1);
    check("t6_x", ctrl_x, 0);
    rst_n = 1'b1;
    base_rise = rise_cnt;
    repeat (20) @(negedge clk);
    check("t6_no_strobe", rise_cnt - base_rise, 0);
    check("t6_count_after", queue_count, 0);

    check("both_strobes", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
